thermal_monitor: RTL

THERMAL_MONITOR -- requirements
Module: thermal_monitor

---
 rtl/thermal_monitor.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/thermal_monitor.sv
// Multi-sensor thermal monitor: IIR filtering, fault masking, hottest-channel select and hysteretic NORMAL/WARM/HOT/CRITICAL FSM.
// Latency: max two edges after each sample tick, state three edges after it; no backpressure; THERMAL_MON_SHUTDOWN_EN adds the shutdown dwell.
`timescale 1ns/1ps
module thermal_monitor #(
  parameter int NUM_SENSORS = 4,
  parameter int SAMPLE_DIV  = 16,
  parameter int AVG_SHIFT   = 2,
  parameter int FAULT_LIMIT = 3,
  parameter int CRIT_DWELL  = 4,
  localparam int IDW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_SENSORS*8-1:0] temp_celsius,
  input  logic [NUM_SENSORS-1:0]   sensor_valid,
  input  logic [7:0]               warn_thresh,
  input  logic [7:0]               hot_thresh,
  input  logic [7:0]               crit_thresh,
  input  logic [7:0]               hyst,
  output logic [7:0]               max_temp,
  output logic [IDW-1:0]           max_sensor_id,
  output logic [1:0]               thermal_state,
  output logic [2:0]               throttle_level,
  output logic                     thermal_irq,
  output logic [NUM_SENSORS-1:0]   fault_mask,
  output logic                     shutdown_req
);

  localparam int CW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW  = 8 + AVG_SHIFT;
  localparam int FCW = $clog2(FAULT_LIMIT + 1);

  typedef enum logic [1:0] {NORMAL = 2'd0, WARM = 2'd1, HOT = 2'd2, CRITICAL = 2'd3} state_t;

  logic [CW-1:0]          cnt;
  logic                   tick;
  logic                   tick_d;
  logic                   eval_d;
  logic [AW-1:0]          acc   [NUM_SENSORS];
  logic [FCW-1:0]         fcnt  [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] seeded;
  logic [7:0]             filt  [NUM_SENSORS];
  logic [7:0]             best_t;
  logic [IDW-1:0]         best_id;
  logic                   found;
  state_t                 state;
  state_t                 up_tgt;
  state_t                 nxt_state;
  logic [7:0]             warn_lo;
  logic [7:0]             hot_lo;
  logic [7:0]             crit_lo;

  assign tick = enable && (cnt == CW'(SAMPLE_DIV - 1));
  assign thermal_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!enable || cnt == CW'(SAMPLE_DIV - 1))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // A valid sample clears the channel's fault history on the same tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seeded     <= '0;
      fault_mask <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        acc[i]  <= '0;
        fcnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (sensor_valid[i]) begin
          seeded[i]     <= 1'b1;
          fcnt[i]       <= '0;
          fault_mask[i] <= 1'b0;
          if (seeded[i])
            acc[i] <= acc[i] - (acc[i] >> AVG_SHIFT) + AW'(temp_celsius[8*i +: 8]);
          else
            acc[i] <= AW'(temp_celsius[8*i +: 8]) << AVG_SHIFT;
        end else begin
          if (fcnt[i] != FCW'(FAULT_LIMIT))
            fcnt[i] <= fcnt[i] + 1'b1;
          if (fcnt[i] >= FCW'(FAULT_LIMIT - 1))
            fault_mask[i] <= 1'b1;
        end
      end
    end
  end

  // Strict compare keeps the lowest index on ties; no eligible channel reads as 8'hFF.
  always_comb begin
    best_t  = 8'hFF;
    best_id = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      filt[i] = acc[i][AW-1:AVG_SHIFT];
      if (seeded[i] && !fault_mask[i] && (!found || filt[i] > best_t)) begin
        found   = 1'b1;
        best_t  = filt[i];
        best_id = IDW'(i);
      end
    end
  end

  assign warn_lo = (warn_thresh > hyst) ? warn_thresh - hyst : 8'd0;
  assign hot_lo  = (hot_thresh  > hyst) ? hot_thresh  - hyst : 8'd0;
  assign crit_lo = (crit_thresh > hyst) ? crit_thresh - hyst : 8'd0;

  always_comb begin
    if (max_temp >= crit_thresh)     up_tgt = CRITICAL;
    else if (max_temp >= hot_thresh) up_tgt = HOT;
    else if (max_temp >= warn_thresh) up_tgt = WARM;
    else                              up_tgt = NORMAL;
    nxt_state = state;
    if (up_tgt > state)
      nxt_state = up_tgt;
    else begin
      case (state)
        CRITICAL: if (max_temp < crit_lo) nxt_state = HOT;
        HOT:      if (max_temp < hot_lo)  nxt_state = WARM;
        WARM:     if (max_temp < warn_lo) nxt_state = NORMAL;
        default:  nxt_state = state;
      endcase
    end
  end

  function automatic logic [2:0] throttle_of(input state_t s);
    case (s)
      WARM:     return 3'd2;
      HOT:      return 3'd5;
      CRITICAL: return 3'd7;
      default:  return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d         <= 1'b0;
      eval_d         <= 1'b0;
      max_temp       <= '0;
      max_sensor_id  <= '0;
      state          <= NORMAL;
      throttle_level <= '0;
      thermal_irq    <= 1'b0;
    end else begin
      thermal_irq <= 1'b0;
      if (enable) begin
        tick_d <= tick;
        eval_d <= tick_d;
        if (tick_d) begin
          max_temp      <= best_t;
          max_sensor_id <= best_id;
        end
        if (eval_d) begin
          state          <= nxt_state;
          throttle_level <= throttle_of(nxt_state);
          thermal_irq    <= (nxt_state > state);
        end
      end
    end
  end

`ifdef THERMAL_MON_SHUTDOWN_EN
  localparam int DW = $clog2(CRIT_DWELL + 1);
  logic [DW-1:0] dwell;

  // Request latches once CRITICAL persists for CRIT_DWELL evaluations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell        <= '0;
      shutdown_req <= 1'b0;
    end else if (enable && eval_d) begin
      if (nxt_state == CRITICAL) begin
        if (dwell != DW'(CRIT_DWELL))
          dwell <= dwell + 1'b1;
        if (dwell >= DW'(CRIT_DWELL - 1))
          shutdown_req <= 1'b1;
      end else begin
        dwell <= '0;
      end
    end
  end
`else
  assign shutdown_req = 1'b0;
`endif

endmodule
